inst_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the instruction memory and the single-cycle core.
- Accepts a framed byte stream through a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words into instruction memory and holds the core in reset until a complete, checksum-verified image is in place.
- Replaces compile-time memory initialisation when images are loaded at run time.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/byte_assembler.sv | 32 +++
 rtl/inst_loader.sv | 107 ++++++++++
 tb/tb_inst_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM encoding and frame field widths.
package riscv_pkg;

    localparam int LEN_W      = 16;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Collects four accepted bytes into a little-endian word; word_valid is high
// combinationally while the fourth byte is being accepted.
module byte_assembler
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              areset,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]                         lane;
    logic [(WORD_BYTES-1)*BYTE_W-1:0]   low_bytes;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (areset) begin
            lane      <= 2'd0;
            low_bytes <= '0;
        end else if (byte_valid) begin
            lane      <= lane + 2'd1;
            low_bytes <= {byte_data, low_bytes[(WORD_BYTES-1)*BYTE_W-1:BYTE_W]};
        end
    end

    // After three shifts low_bytes holds {b2, b1, b0}; the live byte is the top lane.
    assign word_valid = byte_valid && (lane == 2'd3);
    assign word       = {byte_data, low_bytes};

endmodule

// File: rtl/inst_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame, writes words to
// instruction memory and releases the core only after the checksum matches.
module inst_loader
    import riscv_pkg::*;
#(
    parameter int n           = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [n-1:0]      imem_addr,
    output logic [n-1:0]      imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    state_t             state, state_nxt;
    logic               accept;
    logic               word_valid;
    logic [WORD_W-1:0]  word;
    logic [BYTE_W-1:0]  len_lo;
    logic [BYTE_W-1:0]  csum;
    logic [LEN_W-1:0]   len_rx;
    logic [LEN_W-1:0]   word_count;
    logic [LEN_W-1:0]   word_idx;
    logic [n-1:0]       wr_addr;

    // Ready is gated by areset so nothing is taken while reset is held.
    assign rx_ready = !areset && (state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM});
    assign accept   = rx_valid && rx_ready;
    assign len_rx   = {rx_data, len_lo};
    assign wr_addr  = n'(BASE_ADDR) + (n'(word_idx) << 2);

    byte_assembler u_assembler (
        .clk        (clk),
        .areset     (areset),
        .byte_valid (accept && (state == S_DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (areset) state <= S_LEN0;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        error     = 1'b0;
        core_rst  = 1'b1;
        case (state)
            S_LEN0: if (accept) state_nxt = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if (len_rx > LEN_W'(DEPTH_WORDS)) state_nxt = S_ERR;
                    else if (len_rx == '0)            state_nxt = S_CSUM;
                    else                              state_nxt = S_DATA;
                end
            end
            S_DATA: if (word_valid && (word_idx == word_count - LEN_W'(1))) state_nxt = S_CSUM;
            S_CSUM: if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
            S_DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
            end
            S_ERR:   error = 1'b1;
            default: state_nxt = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            len_lo     <= '0;
            word_count <= '0;
            word_idx   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= n'(BASE_ADDR);
            imem_wdata <= '0;
        end else begin
            imem_we <= word_valid;
            if (word_valid) begin
                imem_addr  <= wr_addr;
                imem_wdata <= n'(word);
                word_idx   <= word_idx + LEN_W'(1);
            end
            if (accept) begin
                case (state)
                    S_LEN0:  len_lo     <= rx_data;
                    S_LEN1:  word_count <= len_rx;
                    S_DATA:  csum       <= csum ^ rx_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader with hand-computed frames and expected writes.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        areset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int total    = 0;
    int bad      = 0;
    int wr_count = 0;
    logic [31:0] pay [64];

    inst_loader #(
        .n           (32),
        .DEPTH_WORDS (64),
        .BASE_ADDR   (0)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Each write pulse is seen at exactly one falling edge per cycle it stays high.
    always @(negedge clk) if (imem_we) wr_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        areset   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", rx_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_core_rst", core_rst, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        areset = 1'b0;
        #1;
        check("rst_ready_rise", rx_ready, 1);
    endtask

    // Leaves rx_valid high so consecutive calls with gap=0 present bytes back-to-back.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit took = 1'b0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 16 && !took; i++) begin
            @(negedge clk);
            if (rx_ready) took = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!took) check("accept_timeout", {31'd0, took}, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input logic [31:0] exp_addr);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
        check("wr_we", imem_we, 1);
        check("wr_addr", imem_addr, exp_addr);
        check("wr_data", imem_wdata, w);
        check("wr_ready", rx_ready, 1);
    endtask

    task automatic run_good_frame(input int gap);
        int base = wr_count;
        pay[0] = 32'h0000_0513;
        pay[1] = 32'h0010_0093;
        send_byte(8'h02, gap);
        send_byte(8'h00, gap);
        send_word(pay[0], gap, 32'h0);
        send_word(pay[1], gap, 32'h4);
        check("good_done_pre", done, 0);
        check("good_core_rst_pre", core_rst, 1);
        // 13^05^00^00^93^00^10^00 = 0x95
        send_byte(8'h95, gap);
        rx_valid = 1'b0;
        check("good_done", done, 1);
        check("good_core_rst", core_rst, 0);
        check("good_ready", rx_ready, 0);
        check("good_error", error, 0);
        check("good_wr_count", wr_count - base, 2);
    endtask

    initial begin
        int base;
        logic [7:0] cs;
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [7:0] cs;

        // Back-to-back frame.
        apply_reset();
        run_good_frame(0);

        // Same frame with a one-cycle gap before every byte.
        apply_reset();
        run_good_frame(1);

        // Bad checksum: 0x01 sent, correct is 0x00.
        apply_reset();
        base = wr_count;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hDDCC_BBAA, 0, 32'h0);
        send_byte(8'h01, 0);
        check("csum_error", error, 1);
        check("csum_done", done, 0);
        check("csum_core_rst", core_rst, 1);
        check("csum_ready", rx_ready, 0);
        rx_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("err_sticky", error, 1);
        check("err_ready", rx_ready, 0);
        check("csum_wr_count", wr_count - base, 1);

        // Oversized length: N=65.
        apply_reset();
        base = wr_count;
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        check("big_error", error, 1);
        check("big_ready", rx_ready, 0);
        check("big_core_rst", core_rst, 1);
        repeat (3) @(posedge clk);
        #1;
        check("big_wr_count", wr_count - base, 0);

        // Empty image.
        apply_reset();
        base = wr_count;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        check("empty_done", done, 1);
        check("empty_core_rst", core_rst, 0);
        check("empty_wr_count", wr_count - base, 0);

        // Full-capacity image, N=64; last address 0xFC.
        apply_reset();
        base = wr_count;
        cs = 8'h00;
        for (int i = 0; i < 64; i++) begin
            pay[i] = {8'(i), 8'(i + 1), 8'hA5, 8'(3 * i)};
            cs = cs ^ pay[i][7:0] ^ pay[i][15:8] ^ pay[i][23:16] ^ pay[i][31:24];
        end
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 64; i++) send_word(pay[i], 0, 32'(4 * i));
        check("full_last_addr", imem_addr, 32'h0000_00FC);
        send_byte(cs, 0);
        rx_valid = 1'b0;
        check("full_done", done, 1);
        check("full_wr_count", wr_count - base, 64);

        // Abort after two bytes of word 1, then a fresh frame.
        apply_reset();
        base = wr_count;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h0000_0513, 0, 32'h0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        areset   = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_we", imem_we, 0);
        check("abort_addr", imem_addr, 32'h0);
        check("abort_wdata", imem_wdata, 32'h0);
        check("abort_core_rst", core_rst, 1);
        check("abort_ready", rx_ready, 0);
        check("abort_error", error, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_wr_count", wr_count - base, 1);
        areset = 1'b0;
        #1;
        run_good_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
